// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline:
// hazard FSM states, register zero and opcode decoding.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // rt is a source operand for R-type, beq and sw
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/detector_loaduse.sv
// Load-use comparator: a load in ID/EX writes a register
// that the instruction in IF/ID is about to read.
module detector_loaduse
    import pipeline_pkg::*;
(
    input  logic       idexMemRead,
    input  logic [4:0] idexRt,
    input  logic [4:0] ifidRs,
    input  logic [4:0] ifidRt,
    input  logic       ifidUsesRt,
    output logic       loadUse
);

    logic rsHit;
    logic rtHit;

    // register zero is hardwired, so a load to it is harmless
    always_comb begin
        rsHit   = (idexRt == ifidRs);
        rtHit   = ifidUsesRt && (idexRt == ifidRt);
        loadUse = idexMemRead && (idexRt != REG_ZERO) && (rsHit || rtHit);
    end

endmodule

// File: rtl/controle_hazard_pipeline.sv
// Hazard/sequencing controller: load-use stalls, branch
// flushes, memory-wait freezes and event counters.
module controle_hazard_pipeline
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idexMemRead,
    input  logic [4:0]       idexRt,
    input  logic [4:0]       ifidRs,
    input  logic [4:0]       ifidRt,
    input  logic             ifidUsesRt,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             ctrl,
    output logic             ctrlDesvio,
    output logic             pipeFreeze,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    hz_state_t  state;
    hz_state_t  stateNext;
    logic [1:0] fcnt;
    logic [1:0] fcntNext;
    logic       loadUse;
    logic       memWait;
    logic       stallInc;
    logic       flushInc;

    detector_loaduse u_lu (
        .idexMemRead (idexMemRead),
        .idexRt      (idexRt),
        .ifidRs      (ifidRs),
        .ifidRt      (ifidRt),
        .ifidUsesRt  (ifidUsesRt),
        .loadUse     (loadUse)
    );

    assign memWait = memReq && !memReady;

    // next state and Mealy outputs: reset > MW > flush > branch > LU
    always_comb begin
        stateNext  = RUN;
        fcntNext   = fcnt;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        ctrl       = 1'b0;
        ctrlDesvio = 1'b0;
        pipeFreeze = 1'b0;
        stallInc   = 1'b0;
        flushInc   = 1'b0;
        if (!reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            ctrl       = 1'b1;
            ctrlDesvio = 1'b1;
            fcntNext   = 2'd0;
        end else if (memWait) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            pipeFreeze = 1'b1;
            stallInc   = 1'b1;
            stateNext  = MEM_WAIT;
            fcntNext   = 2'd0;
        end else if (state == FLUSH) begin
            ifidFlush  = 1'b1;
            ctrlDesvio = 1'b1;
            fcntNext   = fcnt - 2'd1;
            if (fcnt > 2'd1) begin
                stateNext = FLUSH;
            end
        end else if (branchTaken) begin
            ifidFlush  = 1'b1;
            ctrlDesvio = 1'b1;
            flushInc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                stateNext = FLUSH;
                fcntNext  = FLUSH_INIT;
            end
        end else if (loadUse) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ctrl      = 1'b1;
            stallInc  = 1'b1;
        end
    end

    // state register, flush countdown and event counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= RUN;
            fcnt       <= 2'd0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state <= stateNext;
            fcnt  <= fcntNext;
            if (stallInc) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (flushInc) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_controle_hazard_pipeline.sv
// Scoreboard bench for controle_hazard_pipeline with
// FLUSH_CYCLES=3 and 4-bit counters.
module tb_controle_hazard_pipeline;

    localparam int FC = 3;
    localparam int CW = 4;

    // {pcWrite, ifidWrite, ifidFlush, ctrl, ctrlDesvio, pipeFreeze}
    localparam logic [5:0] O_NORM = 6'b110000;
    localparam logic [5:0] O_LU   = 6'b000100;
    localparam logic [5:0] O_MW   = 6'b000001;
    localparam logic [5:0] O_FL   = 6'b111010;
    localparam logic [5:0] O_RST  = 6'b001110;

    typedef struct {
        logic [5:0]    o;
        logic [CW-1:0] s;
        logic [CW-1:0] f;
        string         nm;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          idexMemRead = 1'b0;
    logic [4:0]    idexRt = '0;
    logic [4:0]    ifidRs = '0;
    logic [4:0]    ifidRt = '0;
    logic          ifidUsesRt = 1'b0;
    logic          branchTaken = 1'b0;
    logic          memReq = 1'b0;
    logic          memReady = 1'b0;
    logic          pcWrite;
    logic          ifidWrite;
    logic          ifidFlush;
    logic          ctrl;
    logic          ctrlDesvio;
    logic          pipeFreeze;
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;
    logic [5:0]    got;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    controle_hazard_pipeline #(
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .idexMemRead (idexMemRead),
        .idexRt      (idexRt),
        .ifidRs      (ifidRs),
        .ifidRt      (ifidRt),
        .ifidUsesRt  (ifidUsesRt),
        .branchTaken (branchTaken),
        .memReq      (memReq),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .ifidFlush   (ifidFlush),
        .ctrl        (ctrl),
        .ctrlDesvio  (ctrlDesvio),
        .pipeFreeze  (pipeFreeze),
        .stallCount  (stallCount),
        .flushCount  (flushCount)
    );

    always #5 clock = ~clock;

    assign got = {pcWrite, ifidWrite, ifidFlush, ctrl, ctrlDesvio, pipeFreeze};

    // monitor: compare the cycle's outputs against the oldest expectation
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if (got !== e.o) begin
                mismatched++;
                $display("FAIL %s outputs: got %b want %b", e.nm, got, e.o);
            end
            compared++;
            if (stallCount !== e.s) begin
                mismatched++;
                $display("FAIL %s stallCount: got %0d want %0d", e.nm, stallCount, e.s);
            end
            compared++;
            if (flushCount !== e.f) begin
                mismatched++;
                $display("FAIL %s flushCount: got %0d want %0d", e.nm, flushCount, e.f);
            end
        end
    end

    task automatic step(
        input logic       r,
        input logic       mr,
        input logic [4:0] xrt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       ur,
        input logic       br,
        input logic       rq,
        input logic       rd,
        input logic [5:0] eo,
        input int         es,
        input int         ef,
        input string      nm
    );
        exp_t e;
        @(posedge clock);
        #1;
        reset       = r;
        idexMemRead = mr;
        idexRt      = xrt;
        ifidRs      = rs;
        ifidRt      = rt;
        ifidUsesRt  = ur;
        branchTaken = br;
        memReq      = rq;
        memReady    = rd;
        e.o  = eo;
        e.s  = CW'(es);
        e.f  = CW'(ef);
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [5:0] eo, input int es, input int ef, input string nm);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, eo, es, ef, nm);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0, "reset");
        idle(O_NORM, 0, 0, "run_idle");
        step(1, 1, 8, 8, 0, 0, 0, 0, 0, O_LU, 0, 0, "lu_rs");
        idle(O_NORM, 1, 0, "lu_release");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 1, 0, "r0_no_stall");
        step(1, 1, 8, 3, 8, 0, 0, 0, 0, O_NORM, 1, 0, "rt_unused");
        step(1, 1, 8, 3, 8, 1, 0, 0, 0, O_LU, 1, 0, "lu_rt");
        step(1, 1, 8, 8, 0, 0, 1, 0, 0, O_FL, 2, 0, "br_over_lu");
        step(1, 1, 8, 8, 0, 0, 1, 0, 0, O_FL, 2, 1, "flush2_br_ign");
        idle(O_FL, 2, 1, "flush3");
        idle(O_NORM, 2, 1, "flush_done");
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, O_MW, 2, 1, "mw1");
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, O_MW, 3, 1, "mw2");
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, O_MW, 4, 1, "mw3");
        step(1, 0, 0, 0, 0, 0, 1, 1, 1, O_FL, 5, 1, "mw_rel_br");
        idle(O_FL, 5, 2, "mw_flush2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, O_MW, 5, 2, "mw_in_flush");
        step(1, 1, 8, 8, 0, 0, 0, 1, 0, O_MW, 6, 2, "mw_lu_ign");
        step(1, 1, 8, 8, 0, 0, 0, 1, 1, O_LU, 7, 2, "mw_rel_lu");
        idle(O_NORM, 8, 2, "mw_after");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, O_FL, 8, 2, "br_pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 8, 3, "rst_mid_flush");
        idle(O_NORM, 0, 0, "rst_clr");
        idle(O_NORM, 0, 0, "rst_run");
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 8, 8, 0, 0, 0, 0, 0, O_LU, i, 0, "wrap_lu");
        end
        idle(O_NORM, 0, 0, "wrap_zero");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, O_MW, 0, 0, "mw_pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST, 1, 0, "rst_mid_mw");
        idle(O_NORM, 0, 0, "rst_mw_clr");
        begin
            int budget;
            budget = 10;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clock);
                budget--;
            end
            if (sb.size() > 0) begin
                compared++;
                mismatched++;
                $display("FAIL drain: got %0d pending want 0", sb.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/controle_hazard_pipeline.md
# controle_hazard_pipeline

Hazard and sequencing controller for the 5-stage MIPS pipeline. It detects load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory waits. It drives the PC write enable, the IF/ID write/flush, the ID/EX bubble (`ctrl`) and flush (`ctrlDesvio`) inputs, and a global freeze for the downstream pipeline registers. It also keeps stall/flush event counters for performance measurement.

## Interface
- `FLUSH_CYCLES`, 1: consecutive cycles of flush after a taken branch/jump; legal range 1..3.
- `CNT_W`, 16: width of the performance counters.

- `clock`  in  1  single system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `idexMemRead`  in  1  instruction in ID/EX is a load
- `idexRt`  in  5  destination register of the ID/EX load
- `ifidRs`  in  5  rs field of the instruction in IF/ID
- `ifidRt`  in  5  rt field of the instruction in IF/ID
- `ifidUsesRt`  in  1  IF/ID instruction reads rt (R-type, beq, sw)
- `branchTaken`  in  1  EX resolved a taken beq or a jump this cycle
- `memReq`  in  1  MEM stage issues a data-memory access
- `memReady`  in  1  data memory completes the access this cycle
- `pcWrite`  out  1  PC register load enable
- `ifidWrite`  out  1  IF/ID load enable
- `ifidFlush`  out  1  IF/ID loads zero (nop)
- `ctrl`  out  1  ID/EX loads a bubble
- `ctrlDesvio`  out  1  ID/EX flush
- `pipeFreeze`  out  1  hold enable for EX/MEM and MEM/WB
- `stallCount`  out  CNT_W  cycles spent in load-use stall or memory wait
- `flushCount`  out  CNT_W  taken branch/jump events

## Operation
- The FSM has three states: RUN, MEM_WAIT and FLUSH. A flush counter `fcnt` is 2 bits wide.
- **Load-use condition (LU):** `idexMemRead` and `idexRt != 0` and (`idexRt == ifidRs` or (`ifidUsesRt` and `idexRt == ifidRt`)).
- **Memory wait condition (MW):** `memReq` and not `memReady`.
- **Priority:** MW > `branchTaken` > LU.
- **RUN state:**
  - If MW: `pcWrite=0`, `ifidWrite=0`, `pipeFreeze=1`, `ctrl=0`, `ctrlDesvio=0`; next state is MEM_WAIT.
  - Else if `branchTaken`: `ifidFlush=1`, `ctrlDesvio=1`, `pcWrite=1`, `flushCount` increments. If FLUSH_CYCLES>1, next state is FLUSH with `fcnt=FLUSH_CYCLES-1`.
  - Else if LU: `pcWrite=0`, `ifidWrite=0`, `ctrl=1`; one bubble is inserted.
  - Else: all enables are 1 and all flush/bubble signals are 0.
- **MEM_WAIT state:**
  - Outputs are held as for MW.
  - `branchTaken` and LU are ignored, because the frozen instructions are re-evaluated after release.
  - When `memReady=1`, that cycle produces normal RUN outputs, re-evaluating `branchTaken` and LU. The next state is RUN, or FLUSH when a branch is taken and FLUSH_CYCLES>1.
- **FLUSH state:**
  - Outputs: `ifidFlush=1`, `ctrlDesvio=1`, `pcWrite=1`.
  - `fcnt` decrements each cycle; the FSM returns to RUN after the cycle with `fcnt==1`.
  - A new `branchTaken` in FLUSH is ignored, since the instruction in EX is already squashed.
  - MW in FLUSH takes priority: go to MEM_WAIT, and the remaining flush cycles are discarded.
- **Counters:**
  - `stallCount` increments on every cycle with LU applied or with MW outputs applied.
  - Both counters wrap modulo 2^CNT_W.
- **Register 0:** an `idexRt` of 0 never causes a stall.

## Timing
- The state and both counters are registered.
- All control outputs are combinational (Mealy) from the state plus the current inputs, so they are valid in the same cycle as the hazard.
- The load-use penalty is exactly 1 cycle. LU clears naturally on the next cycle because the bubble sits in ID/EX.
- The taken-branch penalty is FLUSH_CYCLES cycles of squash, with the first on the `branchTaken` cycle.
- The memory-wait penalty is N cycles for N cycles of `memReady=0` while `memReq=1`.
- **While `reset=0`:**
  - `pcWrite=0`, `ifidWrite=0`, `ifidFlush=1`, `ctrl=1`, `ctrlDesvio=1`, `pipeFreeze=0`, so the pipeline fills with bubbles.
  - At the first edge with `reset=0`, the state becomes RUN and `fcnt`, `stallCount` and `flushCount` become 0.
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts the sequence at the next edge; no partial count survives.

## Structure
- **Shared package `pipeline_pkg`:**
  - state encodings RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2
  - `REG_ZERO=5'd0`
  - opcode constants used to derive `ifidUsesRt`, shared with the ID-stage decoder
- **Sub-module `detector_loaduse`:** purely combinational comparator producing LU. It is reused by the future forwarding unit.

## Test plan
- **Load-use:** `idexMemRead=1`, `idexRt=8`, `ifidRs=8` -> one cycle with `pcWrite=0`, `ifidWrite=0`, `ctrl=1`; `stallCount` goes 0->1; the next cycle returns to normal.
- **No false stall:** `idexRt=0`, `ifidRs=0`, `idexMemRead=1` -> no stall. With `ifidRt=8`, `ifidUsesRt=0` and `idexRt=8` -> no stall.
- **Branch vs load-use:** `branchTaken=1` together with LU active -> `ifidFlush=1`, `ctrlDesvio=1`, `ctrl=0`, `pcWrite=1`; `flushCount=1`. With FLUSH_CYCLES=2, the flush is asserted for 2 cycles.
- **Memory wait:** `memReq=1` with `memReady=0` for 3 cycles and then 1 -> `pipeFreeze=1` and `pcWrite=0` for 3 cycles; `stallCount=3`. A `branchTaken` held during the wait is flushed only on the release cycle.
- **Reset mid-flush:** FLUSH_CYCLES=3, `branchTaken`, then `reset=0` on cycle 2 -> the next state is RUN and both counters read 0 after release.
- **Counter wrap:** with CNT_W=4, 16 load-use stalls -> `stallCount` wraps back to 0.
